// File: rtl/axis_frame_checker.sv
// -----------------------------------------------------------------------------
// axis_frame_checker
//
// Purpose:
//   Sink-side checker for an AXI4-Stream of counter-pattern frames. Each frame
//   is expected to be FRAME_LENGTH beats long. On beat n (n >= 1), tdata's low
//   CNTR_WIDTH bits must equal n modulo 2^CNTR_WIDTH, tkeep must be all ones,
//   and tdest must match the tdest of beat 0. Every frame is counted once,
//   either as good (frame_cnt) or as errored (err_cnt). Sticky flags record
//   which kinds of error were seen.
//
// Optional feature (macro AXIS_CHK_BACKPRESSURE_EN):
//   When defined, S_AXIS_tready is throttled by a 16-bit maximal-length LFSR
//   (x^16 + x^14 + x^13 + x^11 + 1, seed 16'hACE1) that advances every cycle.
//   tready is low whenever lfsr[1:0] == 2'b00.
//   When undefined, tready is held high from the first clock edge after reset.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   S_AXIS_*        stream sink (tdata, tdest, tkeep, tlast, tvalid, tready)
//   clear           synchronous clear of frame_cnt, err_cnt and err_flags
//   frame_cnt       saturating count of error-free frames
//   err_cnt         saturating count of frames with at least one error
//   err_flags       sticky: [0] data, [1] short, [2] long, [3] tkeep/tdest
//   last_dest       tdest of the most recent good frame
//   busy            high while a frame is in progress (ACTIVE or DRAIN)
//
// Handshake:
//   A beat transfers only on a rising edge where S_AXIS_tvalid and
//   S_AXIS_tready are both high. Nothing is sampled from tdata, tkeep, tdest
//   or tlast on any other cycle, so those signals may be X while tvalid is low.
// -----------------------------------------------------------------------------
module axis_frame_checker #(
  parameter int DATA_WIDTH   = 32,
  parameter int CNTR_WIDTH   = 8,
  parameter int FRAME_LENGTH = 64,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [3:0]              S_AXIS_tdest,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
  input  logic                    S_AXIS_tlast,
  input  logic                    S_AXIS_tvalid,
  output logic                    S_AXIS_tready,
  input  logic                    clear,
  output logic [STAT_WIDTH-1:0]   frame_cnt,
  output logic [STAT_WIDTH-1:0]   err_cnt,
  output logic [3:0]              err_flags,
  output logic [3:0]              last_dest,
  output logic                    busy
);

  localparam int IDX_W = $clog2(FRAME_LENGTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      beat_idx;
  logic [3:0]            frame_dest;
  logic                  err_pending;  // an earlier beat of this frame failed a check

  logic                  accept;
  logic [CNTR_WIDTH-1:0] idx_mod;
  logic                  data_bad;
  logic                  side_bad;
  logic                  beat_bad;
  logic                  inc_good;
  logic                  inc_err;
  logic [3:0]            set_flags;

  // Upper tdata bits carry no checked content.
  logic                  unused_data;
  assign unused_data = ^S_AXIS_tdata;

  assign accept = S_AXIS_tvalid & S_AXIS_tready;

  // Beat index reduced to the counter-field width (zero-extends when the
  // index is narrower than the field, truncates when wider).
  assign idx_mod  = CNTR_WIDTH'(beat_idx);
  assign data_bad = (S_AXIS_tdata[CNTR_WIDTH-1:0] != idx_mod);
  assign side_bad = (S_AXIS_tkeep != '1) || (S_AXIS_tdest != frame_dest);
  assign beat_bad = data_bad | side_bad;

  // Per-cycle events decoded from the current state and accepted beat.
  always_comb begin
    inc_good  = 1'b0;
    inc_err   = 1'b0;
    set_flags = 4'b0000;
    if (accept) begin
      case (state)
        IDLE: begin
          if (S_AXIS_tlast) begin
            inc_err      = 1'b1;
            set_flags[1] = 1'b1;
          end
        end
        ACTIVE: begin
          set_flags[0] = data_bad;
          set_flags[3] = side_bad;
          if (S_AXIS_tlast) begin
            if ((beat_idx == LAST_IDX) && !err_pending && !beat_bad) begin
              inc_good = 1'b1;
            end else begin
              inc_err = 1'b1;
              if (beat_idx < LAST_IDX) set_flags[1] = 1'b1;
            end
          end else if (beat_idx == LAST_IDX) begin
            set_flags[2] = 1'b1;
          end
        end
        DRAIN: begin
          if (S_AXIS_tlast) inc_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame FSM; busy is registered alongside the state it reflects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat_idx    <= '0;
      frame_dest  <= 4'd0;
      err_pending <= 1'b0;
      busy        <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!S_AXIS_tlast) begin
            frame_dest  <= S_AXIS_tdest;
            beat_idx    <= IDX_W'(1);
            err_pending <= 1'b0;
            state       <= ACTIVE;
            busy        <= 1'b1;
          end
        end
        ACTIVE: begin
          if (S_AXIS_tlast) begin
            beat_idx    <= '0;
            err_pending <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            beat_idx    <= beat_idx + IDX_W'(1);
            err_pending <= err_pending | beat_bad;
            if (beat_idx == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (S_AXIS_tlast) begin
            beat_idx    <= '0;
            err_pending <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Statistics. clear takes priority over any increment on the same cycle;
  // last_dest is not a statistic and is left alone by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      err_flags <= 4'b0000;
      last_dest <= 4'd0;
    end else begin
      if (inc_good) last_dest <= frame_dest;
      if (clear) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
        err_flags <= 4'b0000;
      end else begin
        if (inc_good && (frame_cnt != '1)) frame_cnt <= frame_cnt + STAT_WIDTH'(1);
        if (inc_err && (err_cnt != '1))    err_cnt   <= err_cnt + STAT_WIDTH'(1);
        err_flags <= err_flags | set_flags;
      end
    end
  end

`ifdef AXIS_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr          <= 16'hACE1;
      S_AXIS_tready <= 1'b0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr_fb};
      S_AXIS_tready <= (lfsr[1:0] != 2'b00);
    end
  end
`else
  // Held low in reset, rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) S_AXIS_tready <= 1'b0;
    else     S_AXIS_tready <= 1'b1;
  end
`endif

endmodule

// File: doc/axis_frame_checker.md
AXIS_FRAME_CHECKER -- requirements
Module: axis_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, tdata width in bits; multiple of 8.
REQ-002 SHALL have parameter CNTR_WIDTH, default 8, width of the beat-counter field in tdata[CNTR_WIDTH-1:0]; at most DATA_WIDTH.
REQ-003 SHALL have parameter FRAME_LENGTH, default 64, expected beats per frame; at least 2.
REQ-004 SHALL have parameter STAT_WIDTH, default 16, width of the statistics counters.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port S_AXIS_tdata  in  DATA_WIDTH  stream data.
REQ-008 SHALL have port S_AXIS_tdest  in  4  stream destination.
REQ-009 SHALL have port S_AXIS_tkeep  in  DATA_WIDTH/8  byte qualifiers.
REQ-010 SHALL have port S_AXIS_tlast  in  1  end of frame.
REQ-011 SHALL have port S_AXIS_tvalid  in  1  beat valid.
REQ-012 SHALL have port S_AXIS_tready  out  1  beat accept.
REQ-013 SHALL have port clear  in  1  synchronous clear of statistics and sticky flags.
REQ-014 SHALL have port frame_cnt  out  STAT_WIDTH  frames received without error.
REQ-015 SHALL have port err_cnt  out  STAT_WIDTH  frames received with at least one error.
REQ-016 SHALL have port err_flags  out  4  sticky flags: [0] data mismatch, [1] short frame, [2] long frame, [3] tkeep or tdest error.
REQ-017 SHALL have port last_dest  out  4  tdest of the most recently completed frame.
REQ-018 SHALL have port busy  out  1  high when the FSM is not in IDLE.

Function
REQ-019 SHALL treat a beat as accepted only on a cycle where S_AXIS_tvalid and S_AXIS_tready are both high; all checks SHALL sample only accepted beats.
REQ-020 SHALL implement the FSM states IDLE, ACTIVE and DRAIN.
REQ-021 IDLE: on an accepted beat, SHALL latch tdest as the frame destination, set the beat index to 1 and go to ACTIVE; an accepted beat with tlast high SHALL instead end the frame as short.
REQ-022 ACTIVE: on each accepted beat, SHALL compare tdata[CNTR_WIDTH-1:0] to the beat index modulo 2^CNTR_WIDTH, compare tkeep to all-ones, and compare tdest to the latched destination, then increment the beat index.
REQ-023 SHALL end the frame as good when tlast arrives with beat index = FRAME_LENGTH-1 and no error is pending: frame_cnt +1, last_dest updated, go to IDLE.
REQ-024 SHALL end the frame as short when tlast arrives with beat index < FRAME_LENGTH-1: set err_flags[1], err_cnt +1, go to IDLE.
REQ-025 SHALL go to DRAIN and set err_flags[2] when beat index FRAME_LENGTH-1 is accepted without tlast.
REQ-026 DRAIN: SHALL discard beats without checking until an accepted tlast, then err_cnt +1 and go to IDLE.
REQ-027 SHALL count a frame with any data, tkeep or tdest mismatch once in err_cnt at its tlast, never in frame_cnt; err_flags[0] and [3] SHALL set on the cycle after the offending beat.
REQ-028 SHALL count each frame in exactly one counter, with a latency of one cycle after tlast is accepted.
REQ-029 SHALL saturate frame_cnt and err_cnt at all-ones, with no wrap-around.
REQ-030 The beat index SHALL be $clog2(FRAME_LENGTH)+1 bits wide; the data compare SHALL use its low CNTR_WIDTH bits, so the counter field wraps at 2^CNTR_WIDTH.
REQ-031 clear SHALL zero the counters and err_flags; if clear and a counter increment occur on the same cycle, clear SHALL win. clear SHALL NOT affect FSM state.
REQ-032 SHALL ignore tdata and tlast while tvalid is low, including X values.

Reset
REQ-033 Reset SHALL asynchronously force state IDLE, beat index 0, frame_cnt 0, err_cnt 0, err_flags 0, last_dest 0, busy 0 and S_AXIS_tready 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without counting it; after release, the next accepted beat SHALL start a new frame.
REQ-035 S_AXIS_tready SHALL go high no earlier than the first clk edge after rst deasserts.

Configuration
REQ-036 Macro AXIS_CHK_BACKPRESSURE_EN: when defined, S_AXIS_tready SHALL be driven by a 16-bit maximal-length LFSR (seed 16'hACE1, advancing every cycle), low when lfsr[1:0]==2'b00; when undefined, S_AXIS_tready SHALL be constant 1 after reset and the LFSR SHALL be absent.

Verification
REQ-037 Two 64-beat frames, tdata {24'hFFFFFF, index}, tdest 0 then 1, macro off -> frame_cnt=2, err_cnt=0, err_flags=0, last_dest=1.
REQ-038 64-beat frame with beat 10 carrying counter value 8'h0B -> err_flags=4'b0001, err_cnt=1, frame_cnt=0.
REQ-039 tlast on beat 31 -> err_flags[1]=1, err_cnt=1; a following good frame -> frame_cnt=1.
REQ-040 80-beat frame with tlast on beat 79 -> err_flags[2]=1, busy high through beat 79, err_cnt=1 one cycle after beat 79.
REQ-041 Macro on, 100 good frames with source honouring tready -> frame_cnt=100, err_cnt=0, tready observed low at least once.
REQ-042 rst pulsed at beat 20 of a frame, then one good frame -> frame_cnt=1, err_cnt=0; clear pulse -> all statistics 0.
